mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative HI/LO multiply/divide unit for the MIPS pipeline. It sits in the execute stage, directly downstream of the R-type decoder. It consumes the decoder's 4-bit `mul_control` one-hot together with the rs/rt operand values, and computes MULT/MULTU/DIV/DIVU over multiple cycles into the architectural HI/LO registers. It also services MTHI/MTLO writes and provides HI/LO reads for MFHI/MFLO, with `busy` used by the hazard logic to stall.

## Interface
Parameters:
- `XLEN`, 32: operand width. Only 32 is supported.
- `ITER`, 32: iteration count. Must equal XLEN.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operation offered this cycle.
- `in_ready`  out  1  equal to `!busy`; an operation is accepted when `in_valid & in_ready`.
- `mul_control`  in  4  one-hot operation select: bit0 mult, bit1 multu, bit2 div, bit3 divu.
- `src_a`  in  32  rs value (multiplicand / dividend).
- `src_b`  in  32  rt value (multiplier / divisor).
- `flush`  in  1  abort any in-flight operation (exception/branch squash).
- `hi_we`, `lo_we`  in  1  MTHI/MTLO write enables.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when HI/LO have been updated by an operation.
- `hi`, `lo`  out  32  architectural HI/LO registers.

## Operation
- States: IDLE, CALC, FIX.
- Start condition: in IDLE with `in_valid` and `mul_control != 0`. On start, latch the operation and the operand magnitudes, latch the sign flags, clear the iteration counter, and go to CALC.
  - `mul_control == 0` starts nothing.
  - If several bits are set, priority is mult > multu > div > divu.
- Signed ops (mult, div) compute on absolute values. The magnitude of -2^31 is 2^31, which is exact in 32-bit unsigned.
- Multiply uses 1-bit shift-add per cycle into a 64-bit accumulator.
- Divide uses restoring radix-2 division per cycle: a 33-bit partial-remainder subtract, with quotient bits shifted in.
- CALC runs exactly ITER cycles (5-bit counter, 0..31), then the unit goes to FIX.
- FIX performs the sign correction and writes HI/LO, then returns to IDLE:
  - mult: the 64-bit product is negated when the signs differ.
  - div: the quotient is negated when the signs differ; the remainder takes the dividend's sign.
  - mult/multu: HI = product[63:32], LO = product[31:0].
  - div/divu: LO = quotient, HI = remainder.
- Divide by zero (deterministic; architecturally UNPREDICTABLE): LO = 32'hFFFF_FFFF, HI = dividend, and signed correction is skipped.
- Overflow case 0x8000_0000 / -1 (signed): LO = 0x8000_0000, HI = 0.
- MTHI/MTLO:
  - In IDLE, `hi_we`/`lo_we` write `wdata` at the clock edge, and reads see the new value the next cycle.
  - While `busy`, the writes are ignored; the hazard unit stalls them.
  - A write in the same cycle as a start is performed, and the later FIX overwrites it.
- `flush` in CALC or FIX returns the unit to IDLE next cycle. HI/LO stay unchanged and `done` is not pulsed. `flush` in IDLE suppresses a same-cycle start.
- Reset: the state goes to IDLE, and `hi`, `lo`, `busy`, `done`, the counter and the accumulators all go to 0. `in_ready` becomes 1. Reset mid-operation discards the operation.

## Timing
- Accept at edge ending cycle T.
- CALC occupies cycles T+1..T+32. FIX occupies T+33, with HI/LO registered at the end of T+33.
- In cycle T+34: `done` = 1, `busy` = 0, and the new `hi`/`lo` are visible. A new operation may be accepted in T+34, so the throughput is 1 operation per 34 cycles.
- `busy` = 1 exactly in T+1..T+33. `in_ready` is combinational (`!busy`).
- `hi`/`lo` outputs come directly from registers and never show intermediate values.

## Structure
- The `mult_mc`, `multu_mc`, `div_mc` and `divu_mc` encodings and the state encodings belong in the shared `define.v`, alongside the existing decoder constants.
- One natural sub-module: `div_iter`, the 33-bit subtract/restore step. It is combinational and is instantiated once in the datapath.
- Multiply and divide share the 64-bit shift register (`{rem_or_hi, quot_or_lo}`) and the counter.

## Test plan
- multu 0xFFFF_FFFF × 0xFFFF_FFFF -> `done` at T+34, HI = 0xFFFF_FFFE, LO = 0x0000_0001.
- mult -3 × 7 -> HI = 0xFFFF_FFFF, LO = 0xFFFF_FFEB; mult 0x8000_0000 × 0x8000_0000 -> HI = 0x4000_0000, LO = 0.
- div -7 / 2 -> LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF; divu 100 / 7 -> LO = 14, HI = 2; div 0x8000_0000 / -1 -> LO = 0x8000_0000, HI = 0.
- divu 5 / 0 -> LO = 0xFFFF_FFFF, HI = 5.
- Back-to-back: a second op is offered from T+1, is held off by `in_ready` = 0 until T+34, and is accepted in T+34.
- Corner cases:
  - `flush` at T+10 -> IDLE at T+11, HI/LO keep their prior values, no `done`.
  - MTLO while busy -> ignored.
  - `rst` asserted at T+20 -> all outputs 0 immediately.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared constants and types for the HI/LO multiply/divide unit.
//   - mul_control one-hot encodings, state and operation enums,
//     latched operation control struct, signed-magnitude helper.
package mul_div_unit_pkg;

  localparam int unsigned CNT_W = 5;
  localparam int unsigned MC_W  = 4;

  localparam logic [MC_W-1:0] MULT_MC  = 4'b0001;
  localparam logic [MC_W-1:0] MULTU_MC = 4'b0010;
  localparam logic [MC_W-1:0] DIV_MC   = 4'b0100;
  localparam logic [MC_W-1:0] DIVU_MC  = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  // Operation latched at start, consumed by the FIX step.
  typedef struct packed {
    op_e  op;
    logic neg_res;   // result (product / quotient) must be negated
    logic neg_rem;   // remainder takes a negative dividend's sign
  } op_ctl_t;

  // Magnitude of a 32-bit value; -2^31 maps to 2^31, exact in unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? 32'(~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// One restoring radix-2 divide step.
//   rem_i      : current partial remainder
//   shift_in_i : next dividend bit shifted into the remainder
//   divisor_i  : divisor magnitude
//   rem_o      : updated partial remainder
//   q_bit_o    : quotient bit produced by this step
module div_iter (
  input  logic [31:0] rem_i,
  input  logic        shift_in_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic        q_bit_o
);

  logic [32:0] partial;
  logic [32:0] diff;

  // 33-bit subtract; a remainder that fits means the result is < divisor, so 32 bits suffice.
  always_comb begin
    partial = {rem_i, shift_in_i};
    diff    = partial - {1'b0, divisor_i};
    q_bit_o = (partial >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? 32'(diff) : 32'(partial);
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
//   clk, rst         : clock, async active-high reset
//   in_valid/in_ready: operation handshake (in_ready = !busy)
//   mul_control      : one-hot op select {divu, div, multu, mult}
//   src_a, src_b     : rs / rt operands
//   flush            : abort in-flight operation
//   hi_we, lo_we     : MTHI / MTLO write enables with wdata
//   busy, done       : in-flight flag, one-cycle completion pulse
//   hi, lo           : architectural HI/LO registers
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      mul_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_e     state_q, state_d;
  op_ctl_t    ctl_q, ctl_d;
  logic [31:0] acc_hi_q, acc_hi_d;     // product high half / partial remainder
  logic [31:0] acc_lo_q, acc_lo_d;     // multiplier bits / dividend-then-quotient
  logic [31:0] operand_q, operand_d;   // multiplicand or divisor magnitude
  logic [31:0] dividend_q, dividend_d; // raw dividend for the divide-by-zero result
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        start;
  logic        is_signed;
  op_e         start_op;
  logic [32:0] mul_sum;
  logic [63:0] product;
  logic [31:0] quot_fix, rem_fix;
  logic [31:0] div_rem;
  logic        div_qbit;

  div_iter u_div_iter (
    .rem_i      (acc_hi_q),
    .shift_in_i (acc_lo_q[31]),
    .divisor_i  (operand_q),
    .rem_o      (div_rem),
    .q_bit_o    (div_qbit)
  );

  // Priority decode: mult > multu > div > divu.
  always_comb begin
    start_op  = OP_DIVU;
    is_signed = 1'b0;
    if (mul_control[0]) begin
      start_op  = OP_MULT;
      is_signed = 1'b1;
    end else if (mul_control[1]) begin
      start_op  = OP_MULTU;
    end else if (mul_control[2]) begin
      start_op  = OP_DIV;
      is_signed = 1'b1;
    end
  end

  assign start = (state_q == S_IDLE) && in_valid && !flush && (mul_control != 4'd0);

  // Next-state, datapath step and HI/LO update.
  always_comb begin
    state_d    = state_q;
    ctl_d      = ctl_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    operand_d  = operand_q;
    dividend_d = dividend_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, operand_q} : 33'd0);
    product    = {acc_hi_q, acc_lo_q};
    quot_fix   = acc_lo_q;
    rem_fix    = acc_hi_q;

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          ctl_d.op      = start_op;
          ctl_d.neg_res = is_signed && (src_a[31] ^ src_b[31]);
          ctl_d.neg_rem = is_signed && src_a[31];
          acc_hi_d      = 32'd0;
          dividend_d    = src_a;
          cnt_d         = '0;
          if (start_op == OP_MULT || start_op == OP_MULTU) begin
            operand_d = mag32(src_a, is_signed);
            acc_lo_d  = mag32(src_b, is_signed);
          end else begin
            operand_d = mag32(src_b, is_signed);
            acc_lo_d  = mag32(src_a, is_signed);
          end
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (ctl_q.op == OP_MULT || ctl_q.op == OP_MULTU) begin
            // Shift-add: carry and sum shift right into the 64-bit pair.
            acc_hi_d = mul_sum[32:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
          end else begin
            acc_hi_d = div_rem;
            acc_lo_d = {acc_lo_q[30:0], div_qbit};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (ctl_q.op == OP_MULT || ctl_q.op == OP_MULTU) begin
            if (ctl_q.neg_res) product = 64'(~product + 64'd1);
            hi_d = product[63:32];
            lo_d = product[31:0];
          end else if (operand_q == 32'd0) begin
            hi_d = dividend_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            if (ctl_q.neg_res) quot_fix = 32'(~acc_lo_q + 32'd1);
            if (ctl_q.neg_rem) rem_fix  = 32'(~acc_hi_q + 32'd1);
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ctl_q      <= '0;
      acc_hi_q   <= 32'd0;
      acc_lo_q   <= 32'd0;
      operand_q  <= 32'd0;
      dividend_q <= 32'd0;
      cnt_q      <= '0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctl_q      <= ctl_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      operand_q  <= operand_d;
      dividend_q <= dividend_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign in_ready = !busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed HI/LO results, latency,
// back-to-back handshake, flush, MTHI/MTLO rules and mid-operation reset.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  mul_control;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.XLEN(32), .ITER(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mul_control (mul_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op for one cycle; returns in cycle T+1.
  task automatic start_op(input logic [3:0] mc, input logic [31:0] a, input logic [31:0] b);
    in_valid    = 1'b1;
    mul_control = mc;
    src_a       = a;
    src_b       = b;
    tick();
    in_valid    = 1'b0;
    mul_control = 4'd0;
  endtask

  // Bounded wait for done; n = edges waited.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (done) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] mc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    start_op(mc, a, b);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(n);
    check({tag, "_latency"}, 32'(n), 32'd33);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int n;
    logic early_ready;
    logic saw_done;

    rst = 1'b1; in_valid = 1'b0; mul_control = 4'd0; src_a = '0; src_b = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick(); tick();
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    tick();

    run_op("multu_max", 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    run_op("mult_neg", 4'b0001, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_min", 4'b0001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_neg", 4'b0100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_100_7", 4'b1000, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_ovf", 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("divu_by0", 4'b1000, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    // mult wins over divu when both bits are set: -2 * 3 = -6
    run_op("prio", 4'b1001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // mul_control == 0 starts nothing
    start_op(4'd0, 32'd1, 32'd1);
    check("mc_zero_busy", 32'(busy), 32'd0);

    // MTHI/MTLO in IDLE
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_1234;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_idle", hi, 32'h0000_1234);
    check("mtlo_idle", lo, 32'h0000_1234);

    // Back-to-back: second op held from T+1 until accepted in T+34
    start_op(4'b1000, 32'd100, 32'd7);
    in_valid = 1'b1; mul_control = 4'b0010; src_a = 32'd3; src_b = 32'd5;
    early_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) break;
      tick();
      n++;
    end
    check("b2b_ready_at_T34", 32'(n), 32'd33);
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_lo1", lo, 32'd14);
    tick();
    in_valid = 1'b0; mul_control = 4'd0;
    check("b2b_accept2", 32'(busy), 32'd1);
    wait_done(n);
    check("b2b_latency2", 32'(n), 32'd33);
    check("b2b_hi2", hi, 32'd0);
    check("b2b_lo2", lo, 32'd15);

    // Flush at T+10: IDLE at T+11, HI/LO preserved, no done
    start_op(4'b0001, 32'd7, 32'd9);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("flush_no_done", 32'(saw_done), 32'd0);
    check("flush_hi", hi, 32'd0);
    check("flush_lo", lo, 32'd15);

    // Write in start cycle performed, MTLO while busy ignored, FIX overwrites
    hi_we = 1'b1; wdata = 32'h0000_AAAA;
    start_op(4'b0010, 32'd2, 32'd3);
    hi_we = 1'b0;
    check("mthi_at_start", hi, 32'h0000_AAAA);
    lo_we = 1'b1; wdata = 32'h0000_DEAD;
    tick();
    lo_we = 1'b0;
    check("mtlo_busy_ignored", lo, 32'd15);
    wait_done(n);
    check("mtlo_busy_latency", 32'(n), 32'd32);
    check("mtlo_busy_hi", hi, 32'd0);
    check("mtlo_busy_lo", lo, 32'd6);

    // Reset at T+20 clears everything at once
    start_op(4'b0001, 32'd7, 32'd9);
    repeat (19) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    run_op("post_rst_divu", 4'b1000, 32'd9, 32'd4, 32'd1, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
